// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction field layout, widths and the decode helper.
package pipeline_pkg;

    localparam int INSTR_W        = 32;
    localparam int OPC_W          = 6;
    localparam int REG_W          = 5;
    localparam int NREGS          = 32;
    localparam int IMM_W          = 16;

    localparam int OPC_LSB        = 26;
    localparam int IMMF_BIT       = 29;
    localparam int WS_LSB         = 21;
    localparam int RS1_LSB        = 16;
    localparam int RS2_LSB        = 11;
    localparam int IMM_LSB        = 0;

    localparam int WB_LAT_DEFAULT = 3;

    typedef struct packed {
        logic [OPC_W-1:0]   alu_op;
        logic [REG_W-1:0]   ws;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [INSTR_W-1:0] imm;
        logic               ds;
        logic               we;
    } issue_t;

    // Split an instruction word into the fields handed to stage 2.
    // The imm-form flag lives inside the opcode field, so it is shared with alu_op.
    function automatic issue_t decode_instr(input logic [INSTR_W-1:0] instr);
        issue_t d;
        d        = '0;
        d.alu_op = instr[OPC_LSB +: OPC_W];
        d.ws     = instr[WS_LSB +: REG_W];
        d.rs1    = instr[RS1_LSB +: REG_W];
        d.we     = 1'b1;
        if (instr[IMMF_BIT]) begin
            d.imm = {{(INSTR_W-IMM_W){1'b0}}, instr[IMM_LSB +: IMM_W]};
            d.ds  = 1'b1;
        end else begin
            d.rs2 = instr[RS2_LSB +: REG_W];
        end
        return d;
    endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Fixed-depth shift register of (valid, destination tag) pairs. A tag pushed on
// one edge appears at the exit output DEPTH cycles later, which is the cycle its
// scoreboard bit must be released.
module wb_delay_line
    import pipeline_pkg::*;
#(
    parameter int DEPTH = WB_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid_i,
    input  logic [REG_W-1:0] push_tag_i,
    output logic             exit_valid_o,
    output logic [REG_W-1:0] exit_tag_o
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0]            vld_d;
    logic [DEPTH-1:0][REG_W-1:0] tag_q;
    logic [DEPTH-1:0][REG_W-1:0] tag_d;

    // Stage 0 loads the new tag, every later stage takes its predecessor.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign vld_d[gi] = push_valid_i;
            assign tag_d[gi] = push_tag_i;
        end else begin : g_body
            assign vld_d[gi] = vld_q[gi-1];
            assign tag_d[gi] = tag_q[gi-1];
        end
    end

    // Advance the whole line each cycle; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    assign exit_valid_o = vld_q[DEPTH-1];
    assign exit_tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/issue_ctrl.sv
// Issue stage: decodes the offered instruction, blocks it on RAW/WAW hazards
// against a busy scoreboard, and registers accepted instructions for stage 2.
module issue_ctrl
    import pipeline_pkg::*;
#(
    parameter int WB_LAT = WB_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic               issue_valid,
    output logic [OPC_W-1:0]   issue_alu_op,
    output logic [REG_W-1:0]   issue_ws,
    output logic [REG_W-1:0]   issue_rs1,
    output logic [REG_W-1:0]   issue_rs2,
    output logic [INSTR_W-1:0] issue_imm,
    output logic               issue_ds,
    output logic               issue_we,
    output logic [15:0]        stall_count
);

    issue_t           dec;
    issue_t           issue_q;
    logic             issue_valid_q;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [15:0]      stall_q;
    logic [15:0]      stall_d;
    logic             hazard;
    logic             accept;
    logic             push_valid;
    logic             exit_valid;
    logic [REG_W-1:0] exit_tag;

    assign dec = decode_instr(instr);

    // RS2 is only a real source in register form; in imm form the field is immediate bits.
    assign hazard      = busy_q[dec.rs1] | (~dec.ds & busy_q[dec.rs2]) | busy_q[dec.ws];
    assign instr_ready = ~rst & ~hazard;
    assign accept      = instr_valid & instr_ready;
    assign push_valid  = accept & (dec.ws != '0);

    wb_delay_line #(
        .DEPTH (WB_LAT)
    ) u_wb_delay_line (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (push_valid),
        .push_tag_i   (dec.ws),
        .exit_valid_o (exit_valid),
        .exit_tag_o   (exit_tag)
    );

    // Per-register next state: an exiting tag and a new tag never collide because
    // the new instruction would have seen that register busy and stalled.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        if (gi == 0) begin : g_r0
            assign busy_d[gi] = 1'b0;
        end else begin : g_rn
            logic set_bit;
            logic clr_bit;
            assign set_bit    = push_valid & (dec.ws == REG_W'(gi));
            assign clr_bit    = exit_valid & (exit_tag == REG_W'(gi));
            assign busy_d[gi] = (busy_q[gi] & ~clr_bit) | set_bit;
        end
    end

    // Scoreboard register; reset forgets every outstanding write.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Saturating stall counter next state: counts offered-but-blocked cycles.
    always_comb begin
        stall_d = stall_q;
        if (instr_valid && !instr_ready && !rst && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    // Stage-2 register: valid pulses per accept, fields hold until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
        end else begin
            issue_valid_q <= accept;
            if (accept) begin
                issue_q <= dec;
            end
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_alu_op = issue_q.alu_op;
    assign issue_ws     = issue_q.ws;
    assign issue_rs1    = issue_q.rs1;
    assign issue_rs2    = issue_q.rs2;
    assign issue_imm    = issue_q.imm;
    assign issue_ds     = issue_q.ds;
    assign issue_we     = issue_q.we;
    assign stall_count  = stall_q;

endmodule
